bp_cce_dir_way_group_reader: RTL and testbench

Sequential directory read engine in the CCE that walks one way-group of the coherence directory RAM, one LCE row per access. It compares each stored tag/state against the target tag and consolidates the results into the per-LCE sharers vectors (hit, way, coherence state). The GAD logic and the CCE microcode consume these vectors. It is the producer side of the sharers interface, with a valid/ready request port and a stallable synchronous RAM read port.

---
 rtl/bp_cce_dir_way_group_reader.sv | 150 +++++++++++++++
 tb/tb_bp_cce_dir_way_group_reader.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_cce_dir_way_group_reader.sv
// bp_cce_dir_way_group_reader
// Walks one way-group of the coherence directory RAM, one LCE row per read,
// and builds the per-LCE sharers vectors (hit, hit way, hit way's state).
//
// Ports:
//   clk_i, reset_i          clock, asynchronous active-high reset
//   r_v_i, r_way_group_i,
//   r_tag_i, ready_o        request (valid/ready) carrying way-group and tag
//   ram_v_o, ram_ready_i,
//   ram_addr_o, ram_data_i  directory RAM read port; data returns one cycle
//                           after the handshake, address = {way_group, lce}
//   sharers_v_o             vectors complete and stable
//   sharers_hits_o          per-LCE tag hit
//   sharers_ways_o          per-LCE lowest hitting way
//   sharers_coh_states_o    per-LCE coherence state of that way
module bp_cce_dir_way_group_reader #(
  parameter int unsigned num_lce_p        = 4,
  parameter int unsigned lce_assoc_p      = 4,
  parameter int unsigned num_way_groups_p = 8,
  parameter int unsigned tag_width_p      = 10,
  parameter int unsigned coh_bits_p       = 3,
  localparam int unsigned lg_num_lce_lp   = (num_lce_p <= 1) ? 1 : $clog2(num_lce_p),
  localparam int unsigned lg_lce_assoc_lp = (lce_assoc_p <= 1) ? 1 : $clog2(lce_assoc_p),
  localparam int unsigned lg_wg_lp        = (num_way_groups_p <= 1) ? 1 : $clog2(num_way_groups_p),
  localparam int unsigned entry_width_lp  = tag_width_p + coh_bits_p
) (
  input  logic                                    clk_i,
  input  logic                                    reset_i,
  input  logic                                    r_v_i,
  input  logic [lg_wg_lp-1:0]                     r_way_group_i,
  input  logic [tag_width_p-1:0]                  r_tag_i,
  output logic                                    ready_o,
  output logic                                    ram_v_o,
  input  logic                                    ram_ready_i,
  output logic [lg_wg_lp+lg_num_lce_lp-1:0]       ram_addr_o,
  input  logic [lce_assoc_p*entry_width_lp-1:0]   ram_data_i,
  output logic                                    sharers_v_o,
  output logic [num_lce_p-1:0]                    sharers_hits_o,
  output logic [num_lce_p*lg_lce_assoc_lp-1:0]    sharers_ways_o,
  output logic [num_lce_p*coh_bits_p-1:0]         sharers_coh_states_o
);

  // One extra bit so the issue counter can reach num_lce_p and stop there.
  localparam int unsigned cnt_w_lp = lg_num_lce_lp + 1;
  localparam logic [cnt_w_lp-1:0] num_lce_cnt_lp  = cnt_w_lp'(num_lce_p);
  localparam logic [cnt_w_lp-1:0] last_lce_cnt_lp = cnt_w_lp'(num_lce_p - 1);

  typedef enum logic [1:0] {e_idle, e_read, e_done} state_e;

  state_e state_q, state_n;

  logic [lg_wg_lp-1:0]                  wg_q;
  logic [tag_width_p-1:0]               tag_q;
  logic [cnt_w_lp-1:0]                  issue_cnt_q;
  logic [cnt_w_lp-1:0]                  capture_cnt_q;
  logic                                 pending_q;
  logic                                 v_q;
  logic [num_lce_p-1:0]                 hits_q;
  logic [num_lce_p*lg_lce_assoc_lp-1:0] ways_q;
  logic [num_lce_p*coh_bits_p-1:0]      states_q;

  logic                                 accept;
  logic                                 ram_hs;
  logic [lg_num_lce_lp-1:0]             capture_idx;

  logic                                 dec_hit;
  logic [lg_lce_assoc_lp-1:0]           dec_way;
  logic [coh_bits_p-1:0]                dec_state;
  logic [entry_width_lp-1:0]            entry;

  assign ready_o     = (state_q != e_read);
  assign accept      = r_v_i & ready_o;
  assign ram_v_o     = (state_q == e_read) && (issue_cnt_q < num_lce_cnt_lp);
  assign ram_addr_o  = {wg_q, issue_cnt_q[lg_num_lce_lp-1:0]};
  assign ram_hs      = ram_v_o & ram_ready_i;
  assign capture_idx = capture_cnt_q[lg_num_lce_lp-1:0];

  assign sharers_v_o          = v_q;
  assign sharers_hits_o       = hits_q;
  assign sharers_ways_o       = ways_q;
  assign sharers_coh_states_o = states_q;

  // Row decode: first (lowest-index) valid entry whose tag matches wins.
  always_comb begin
    dec_hit   = 1'b0;
    dec_way   = '0;
    dec_state = '0;
    entry     = '0;
    for (int unsigned w = 0; w < lce_assoc_p; w++) begin
      entry = ram_data_i[w*entry_width_lp +: entry_width_lp];
      if (!dec_hit
          && (entry[coh_bits_p-1:0] != '0)
          && (entry[entry_width_lp-1 -: tag_width_p] == tag_q)) begin
        dec_hit   = 1'b1;
        dec_way   = w[lg_lce_assoc_lp-1:0];
        dec_state = entry[coh_bits_p-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= e_idle;
    else         state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      e_idle, e_done: if (r_v_i) state_n = e_read;
      e_read:         if (pending_q && (capture_cnt_q == last_lce_cnt_lp)) state_n = e_done;
      default:        state_n = e_idle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wg_q          <= '0;
      tag_q         <= '0;
      issue_cnt_q   <= '0;
      capture_cnt_q <= '0;
      pending_q     <= 1'b0;
      v_q           <= 1'b0;
      hits_q        <= '0;
      ways_q        <= '0;
      states_q      <= '0;
    end else if (accept) begin
      wg_q          <= r_way_group_i;
      tag_q         <= r_tag_i;
      issue_cnt_q   <= '0;
      capture_cnt_q <= '0;
      pending_q     <= 1'b0;
      v_q           <= 1'b0;
      hits_q        <= '0;
      ways_q        <= '0;
      states_q      <= '0;
    end else begin
      // Issue of LCE k+1 and capture of LCE k proceed in the same cycle.
      pending_q <= ram_hs;
      if (ram_hs) issue_cnt_q <= issue_cnt_q + cnt_w_lp'(1);
      if (pending_q) begin
        hits_q[capture_idx]                                  <= dec_hit;
        ways_q[capture_idx*lg_lce_assoc_lp +: lg_lce_assoc_lp] <= dec_way;
        states_q[capture_idx*coh_bits_p +: coh_bits_p]       <= dec_state;
        capture_cnt_q <= capture_cnt_q + cnt_w_lp'(1);
        if (capture_cnt_q == last_lce_cnt_lp) v_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bp_cce_dir_way_group_reader.sv
module tb_bp_cce_dir_way_group_reader;

  localparam int NUM_LCE  = 4;
  localparam int ASSOC    = 4;
  localparam int NUM_WG   = 8;
  localparam int TAG_W    = 10;
  localparam int COH      = 3;
  localparam int LG_LCE   = 2;
  localparam int LG_ASSOC = 2;
  localparam int LG_WG    = 3;
  localparam int ENTRY_W  = TAG_W + COH;
  localparam int ROW_W    = ASSOC * ENTRY_W;
  localparam int ADDR_W   = LG_WG + LG_LCE;

  localparam logic [COH-1:0] S_ST = 3'd1;
  localparam logic [COH-1:0] E_ST = 3'd2;
  localparam logic [COH-1:0] M_ST = 3'd6;

  logic                         clk = 1'b0;
  logic                         reset_i = 1'b1;
  logic                         r_v_i = 1'b0;
  logic [LG_WG-1:0]             r_way_group_i = '0;
  logic [TAG_W-1:0]             r_tag_i = '0;
  logic                         ready_o;
  logic                         ram_v_o;
  logic                         ram_ready_i = 1'b1;
  logic [ADDR_W-1:0]            ram_addr_o;
  logic [ROW_W-1:0]             ram_data_i = '0;
  logic                         sharers_v_o;
  logic [NUM_LCE-1:0]           sharers_hits_o;
  logic [NUM_LCE*LG_ASSOC-1:0]  sharers_ways_o;
  logic [NUM_LCE*COH-1:0]       sharers_coh_states_o;

  int errors = 0;
  int checks = 0;

  logic [ROW_W-1:0]  mem [NUM_WG*NUM_LCE];
  logic [ADDR_W-1:0] log_addr [$];
  logic              log_rdy [$];
  int                stall_left = 0;
  bit                rand_stall = 1'b0;
  logic              hs_prev = 1'b0;
  logic [ADDR_W-1:0] addr_prev = '0;

  logic [NUM_LCE-1:0]          exp_hits;
  logic [NUM_LCE*LG_ASSOC-1:0] exp_ways;
  logic [NUM_LCE*COH-1:0]      exp_states;

  bp_cce_dir_way_group_reader #(
    .num_lce_p(NUM_LCE),
    .lce_assoc_p(ASSOC),
    .num_way_groups_p(NUM_WG),
    .tag_width_p(TAG_W),
    .coh_bits_p(COH)
  ) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .r_v_i(r_v_i),
    .r_way_group_i(r_way_group_i),
    .r_tag_i(r_tag_i),
    .ready_o(ready_o),
    .ram_v_o(ram_v_o),
    .ram_ready_i(ram_ready_i),
    .ram_addr_o(ram_addr_o),
    .ram_data_i(ram_data_i),
    .sharers_v_o(sharers_v_o),
    .sharers_hits_o(sharers_hits_o),
    .sharers_ways_o(sharers_ways_o),
    .sharers_coh_states_o(sharers_coh_states_o)
  );

  always #5 clk = ~clk;

  // RAM environment: data for the previous cycle's handshake, garbage otherwise;
  // ready is driven per cycle and every cycle with ram_v_o is logged.
  always @(negedge clk) begin
    if (hs_prev) ram_data_i = mem[addr_prev];
    else         ram_data_i = ROW_W'({$urandom, $urandom});
    if (ram_v_o && stall_left > 0) begin
      ram_ready_i = 1'b0;
      stall_left--;
    end else if (rand_stall) ram_ready_i = ($urandom_range(0, 3) != 0);
    else                     ram_ready_i = 1'b1;
    hs_prev   = ram_v_o && ram_ready_i && !reset_i;
    addr_prev = ram_addr_o;
    if (ram_v_o) begin
      log_addr.push_back(ram_addr_o);
      log_rdy.push_back(ram_ready_i);
    end
  end

  function automatic logic [ENTRY_W-1:0] mk_entry(input logic [TAG_W-1:0] t, input logic [COH-1:0] s);
    return {t, s};
  endfunction

  task automatic set_entry(input int wg, input int lce, input int way, input logic [ENTRY_W-1:0] e);
    mem[wg*NUM_LCE + lce][way*ENTRY_W +: ENTRY_W] = e;
  endtask

  // Every entry of the way-group misses the target tag.
  task automatic fill_nomatch(input int wg, input logic [TAG_W-1:0] tag);
    for (int l = 0; l < NUM_LCE; l++)
      for (int w = 0; w < ASSOC; w++)
        set_entry(wg, l, w, mk_entry(tag ^ TAG_W'($urandom_range(1, 1023)), COH'($urandom_range(0, 7))));
  endtask

  task automatic fill_random(input int wg, input logic [TAG_W-1:0] tag);
    logic [TAG_W-1:0] t;
    for (int l = 0; l < NUM_LCE; l++)
      for (int w = 0; w < ASSOC; w++) begin
        t = ($urandom_range(0, 2) == 0) ? tag : (tag ^ TAG_W'($urandom_range(1, 1023)));
        set_entry(wg, l, w, mk_entry(t, COH'($urandom_range(0, 7))));
      end
  endtask

  // Reference: scan ways from highest to lowest, later (lower) hits overwrite.
  task automatic build_expected(input int wg, input logic [TAG_W-1:0] tag);
    logic [ENTRY_W-1:0] e;
    exp_hits = '0;
    exp_ways = '0;
    exp_states = '0;
    for (int l = 0; l < NUM_LCE; l++)
      for (int w = ASSOC - 1; w >= 0; w--) begin
        e = mem[wg*NUM_LCE + l][w*ENTRY_W +: ENTRY_W];
        if (e[ENTRY_W-1:COH] == tag && e[COH-1:0] != 0) begin
          exp_hits[l] = 1'b1;
          exp_ways[l*LG_ASSOC +: LG_ASSOC] = LG_ASSOC'(w);
          exp_states[l*COH +: COH] = e[COH-1:0];
        end
      end
  endtask

  // Called at a negedge; returns at the negedge of the first cycle with sharers_v_o.
  task automatic do_request(input logic [LG_WG-1:0] wg, input logic [TAG_W-1:0] tag,
                            input int stalls, input bit noise, input int exp_lat, output int lat);
    int k;
    bit addr_ok;
    build_expected(wg, tag);
    log_addr.delete();
    log_rdy.delete();
    stall_left = stalls;
    r_v_i = 1'b1;
    r_way_group_i = wg;
    r_tag_i = tag;
    checks++;
    if (ready_o !== 1'b1) begin errors++; $display("FAIL ready_at_accept: got %b expected 1", ready_o); end
    @(negedge clk);
    r_v_i = noise;
    r_way_group_i = LG_WG'($urandom);
    r_tag_i = TAG_W'($urandom);
    checks++;
    if ({ready_o, sharers_v_o, sharers_hits_o, sharers_ways_o, sharers_coh_states_o} !== '0) begin
      errors++;
      $display("FAIL accept_clear: got rdy=%b v=%b hits=%h ways=%h st=%h expected all 0",
               ready_o, sharers_v_o, sharers_hits_o, sharers_ways_o, sharers_coh_states_o);
    end
    lat = 1;
    while (sharers_v_o !== 1'b1 && lat < 300) begin
      @(negedge clk);
      lat++;
      if (noise && lat <= NUM_LCE) begin
        r_v_i = 1'b1;
        r_way_group_i = LG_WG'($urandom);
        r_tag_i = TAG_W'($urandom);
      end else r_v_i = 1'b0;
    end
    r_v_i = 1'b0;
    checks++;
    if (sharers_v_o !== 1'b1) begin errors++; $display("FAIL scan_timeout: got v=%b expected 1 within 300 cycles", sharers_v_o); end
    if (exp_lat >= 0) begin
      checks++;
      if (lat != exp_lat) begin errors++; $display("FAIL latency: got %0d expected %0d", lat, exp_lat); end
    end
    checks++;
    if ({sharers_hits_o, sharers_ways_o, sharers_coh_states_o} !== {exp_hits, exp_ways, exp_states}) begin
      errors++;
      $display("FAIL vectors: got hits=%h ways=%h st=%h expected hits=%h ways=%h st=%h",
               sharers_hits_o, sharers_ways_o, sharers_coh_states_o, exp_hits, exp_ways, exp_states);
    end
    checks++;
    if (ready_o !== 1'b1) begin errors++; $display("FAIL ready_done: got %b expected 1", ready_o); end
    k = 0;
    addr_ok = 1'b1;
    foreach (log_addr[i]) begin
      if (log_addr[i] !== {wg, LG_LCE'(k)}) addr_ok = 1'b0;
      if (log_rdy[i]) k++;
    end
    checks++;
    if (!addr_ok || k != NUM_LCE) begin
      errors++;
      $display("FAIL addr_seq: got ok=%b reads=%0d expected ok=1 reads=%0d", addr_ok, k, NUM_LCE);
    end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if (ready_o !== 1'b1 ||
        {ram_v_o, ram_addr_o, sharers_v_o, sharers_hits_o, sharers_ways_o, sharers_coh_states_o} !== '0) begin
      errors++;
      $display("FAIL %s: got rdy=%b ramv=%b addr=%h v=%b hits=%h ways=%h st=%h expected rdy=1 rest 0",
               name, ready_o, ram_v_o, ram_addr_o, sharers_v_o, sharers_hits_o, sharers_ways_o, sharers_coh_states_o);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    check_reset_values("reset_state");
    reset_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_values("idle_after_reset");
  endtask

  task automatic test_basic_hit();
    int lat;
    fill_nomatch(3, 10'h2A5);
    set_entry(3, 0, 2, mk_entry(10'h2A5, S_ST));
    do_request(3'd3, 10'h2A5, 0, 1'b0, NUM_LCE + 2, lat);
    checks++;
    if (sharers_hits_o !== 4'b0001 || sharers_ways_o[1:0] !== 2'd2 || sharers_coh_states_o[2:0] !== S_ST ||
        sharers_ways_o[NUM_LCE*LG_ASSOC-1:LG_ASSOC] !== '0 || sharers_coh_states_o[NUM_LCE*COH-1:COH] !== '0) begin
      errors++;
      $display("FAIL basic_hit: got hits=%b ways=%h st=%h expected hits=0001 ways=002 st=001",
               sharers_hits_o, sharers_ways_o, sharers_coh_states_o);
    end
  endtask

  task automatic test_invalid_match();
    int lat;
    fill_nomatch(5, 10'h13C);
    set_entry(5, 0, 1, mk_entry(10'h13C, 3'd0));
    do_request(3'd5, 10'h13C, 0, 1'b0, NUM_LCE + 2, lat);
    checks++;
    if (sharers_hits_o !== '0 || sharers_ways_o !== '0) begin
      errors++;
      $display("FAIL invalid_match: got hits=%b ways=%h expected 0 0", sharers_hits_o, sharers_ways_o);
    end
  endtask

  task automatic test_multi_match();
    int lat;
    fill_nomatch(1, 10'h0F3);
    set_entry(1, 1, 1, mk_entry(10'h0F3, E_ST));
    set_entry(1, 1, 3, mk_entry(10'h0F3, M_ST));
    do_request(3'd1, 10'h0F3, 0, 1'b0, NUM_LCE + 2, lat);
    checks++;
    if (sharers_hits_o !== 4'b0010 || sharers_ways_o[3:2] !== 2'd1 || sharers_coh_states_o[5:3] !== E_ST) begin
      errors++;
      $display("FAIL multi_match: got hits=%b way1=%0d st1=%0d expected hits=0010 way1=1 st1=2",
               sharers_hits_o, sharers_ways_o[3:2], sharers_coh_states_o[5:3]);
    end
  endtask

  task automatic test_stall();
    int lat;
    fill_random(2, 10'h155);
    do_request(3'd2, 10'h155, 3, 1'b0, NUM_LCE + 5, lat);
  endtask

  task automatic test_back_to_back();
    int lat;
    fill_random(6, 10'h3C1);
    fill_random(4, 10'h022);
    do_request(3'd6, 10'h3C1, 0, 1'b0, NUM_LCE + 2, lat);
    do_request(3'd4, 10'h022, 0, 1'b1, NUM_LCE + 2, lat);
  endtask

  task automatic test_reset_mid_scan();
    int n;
    int lat;
    bit seen;
    fill_random(7, 10'h2B0);
    log_addr.delete();
    log_rdy.delete();
    r_v_i = 1'b1;
    r_way_group_i = 3'd7;
    r_tag_i = 10'h2B0;
    @(negedge clk);
    r_v_i = 1'b0;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 50) begin
      foreach (log_rdy[i]) if (log_rdy[i]) seen = 1'b1;
      if (!seen) begin @(negedge clk); n++; end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL mid_scan_handshake: got none expected one within 50 cycles"); end
    @(negedge clk);
    reset_i = 1'b1;
    #1;
    check_reset_values("reset_immediate");
    @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_values("reset_data_ignored");
    fill_random(0, 10'h1E7);
    do_request(3'd0, 10'h1E7, 0, 1'b0, NUM_LCE + 2, lat);
  endtask

  task automatic test_random();
    int lat;
    logic [LG_WG-1:0] wg;
    logic [TAG_W-1:0] tag;
    logic [NUM_LCE*(1+LG_ASSOC+COH)-1:0] held;
    rand_stall = 1'b1;
    for (int i = 0; i < 25; i++) begin
      wg = LG_WG'($urandom);
      tag = TAG_W'($urandom);
      fill_random(int'(wg), tag);
      do_request(wg, tag, 0, bit'($urandom_range(0, 1)), -1, lat);
      if ($urandom_range(0, 1) == 1) begin
        held = {sharers_hits_o, sharers_ways_o, sharers_coh_states_o};
        repeat ($urandom_range(1, 3)) @(negedge clk);
        checks++;
        if (sharers_v_o !== 1'b1 || {sharers_hits_o, sharers_ways_o, sharers_coh_states_o} !== held) begin
          errors++;
          $display("FAIL done_hold: got v=%b vec=%h expected v=1 vec=%h", sharers_v_o,
                   {sharers_hits_o, sharers_ways_o, sharers_coh_states_o}, held);
        end
      end
    end
    rand_stall = 1'b0;
  endtask

  initial begin
    for (int a = 0; a < NUM_WG*NUM_LCE; a++) mem[a] = ROW_W'({$urandom, $urandom});
    test_reset();
    test_basic_hit();
    test_invalid_match();
    test_multi_match();
    test_stall();
    test_back_to_back();
    test_reset_mid_scan();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
